grad_weight_update: RTL and testbench
=====================================

Name: grad_weight_update

Overview:
- Consumer of the gate-derivative stream produced by the GRU hidden-layer derivative blocks; also the producer of the packed 4-lane weight vector `w` those blocks read.
- For each accepted sample, forms a per-lane gradient g_j = err·d·h_j in fixed point and accumulates it over a batch of NSAMP samples.
- At batch end, applies w_j ← w_j − (acc_j >>> LR_SHIFT) with saturation and publishes the new vector.
- Closes the training loop: derivative out → weight update → w back in.

Parameters:
- DATABIT, 16: lane / sample width, signed two's complement.
- HTNUM, 64: packed weight vector width (4 lanes × DATABIT).
- FRAC, 14: fractional bits; 1.0 = 0x4000.
- ACCW, 20: accumulator width per lane, signed.
- LR_SHIFT, 6: learning-rate right shift.
- NSAMP, 4: samples per batch (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-high (1 = reset).
- init  in  1  load w_init, abort current batch.
- w_init  in  HTNUM  initial weights; lane j = bits [16j+15:16j].
- d_valid  in  1  sample valid.
- d_ready  out  1  sample accept.
- d_in  in  DATABIT  gate derivative sample.
- err  in  DATABIT  back-propagated error, sampled with d_in.
- h_prev  in  HTNUM  4 hidden-state lanes, sampled with d_in.
- w  out  HTNUM  current weights, registered.
- w_valid  out  1  one-cycle pulse on weight update.
- busy  out  1  high in DRAIN/UPDATE.

Behaviour:
- **Reset** (rst_n=1 at edge): w=0, all acc=0, sample count=0, pipeline valids=0, state IDLE, d_ready=0, w_valid=0, busy=0. Reset overrides init.
- **States:**
  - IDLE: d_ready=0; init → ACC.
  - ACC: d_ready=1.
  - DRAIN: d_ready=0, busy=1.
  - UPDATE: d_ready=0, busy=1; always one cycle.
- **Accept** = d_valid & d_ready at the edge. d_in, err and h_prev are captured on the accept edge only.
- **Pipeline** (accept at edge E):
  - E+1: p = sat16((err·d_in) >>> FRAC), from the full 32-bit product.
  - E+2: g_j = sat16((p·h_j) >>> FRAC) for all 4 lanes in parallel.
  - E+3: acc_j = satACCW(acc_j + g_j).
  - All shifts are arithmetic (floor). Saturation clamps to the signed min/max of the target width.
  - One accept per cycle is sustained.
- **Batch end:**
  - Count increments on each accept.
  - The accept that makes count = NSAMP moves the FSM ACC→DRAIN at that edge and resets count to 0.
  - DRAIN exits when the pipeline is empty and the last acc update is done, i.e. it is in DRAIN for edges E+1..E+3.
  - UPDATE at edge E+4: w_j = sat16(w_j − (acc_j >>> LR_SHIFT)), all acc cleared, state → ACC.
  - w_valid=1 for exactly the cycle following edge E+4; d_ready=1 again in that same cycle.
- **d_valid while d_ready=0** (IDLE/DRAIN/UPDATE): ignored. No capture, no count change; the upstream holds the sample.
- **init** (any state, no reset):
  - w=w_init; acc, count and pipeline valids cleared; state → ACC; w_valid not pulsed.
  - In-flight samples are discarded.
  - An accept in the same cycle as init is also discarded.
- **w output:** changes only on reset, init or UPDATE; stable otherwise.
- **Width/overflow:** every saturation point listed above is mandatory; no wrap-around anywhere.

Test Plan:
1. Reset for 2 cycles, then release with init=0 → w=0, d_ready=0, w_valid=0, busy=0; d_valid=1 for 5 cycles is not accepted and never produces w_valid.
2. init with all lanes 0x1000, then 4 back-to-back samples err=0x4000, d_in=0x4000, all h=0x4000 → each g=0x4000, acc=0x10000, delta=0x400; w_valid pulses in the cycle after edge E+4 (E = last accept); all lanes = 0x0C00; busy high for exactly 4 cycles.
3. w_init lanes 0x1000, 4 samples err=0xC000, d_in=0x4000, h0=0x2000, h1..h3=0 → lane0 = 0x1200, lanes1..3 remain 0x1000.
4. Saturation: lane0 init 0x7F00, 4 samples err=0x8000, d_in=0x7FFF, h0=0x7FFF → p and g saturate to 0x8000, acc=−131072, delta=−2048; lane0 saturates to 0x7FFF (not 0x8700).
5. Backpressure: hold d_valid=1 continuously across 2 batches → exactly 4 accepts per batch, no accepts during DRAIN/UPDATE, 2 w_valid pulses spaced 8 cycles apart (4 accept + 4 busy); w matches 2 sequential applications of scenario 2 (0x0C00 then 0x0800).
6. Mid-batch abort: after 2 accepts, assert init with w_init=0x1000 (and separately rst_n=1) → no w_valid; after init, the next 4 samples from scenario 2 yield exactly 0x0C00; after reset, w=0 and state IDLE.

Source files
------------

// File: rtl/grad_weight_update.sv
// Batched weight update for the GRU derivative path: accumulates err*d*h per lane over NSAMP
// samples and applies a learning-rate-scaled saturating step to the packed weight vector.
module grad_weight_update #(
  parameter int unsigned DATABIT  = 16,
  parameter int unsigned HTNUM    = 64,
  parameter int unsigned FRAC     = 14,
  parameter int unsigned ACCW     = 20,
  parameter int unsigned LR_SHIFT = 6,
  parameter int unsigned NSAMP    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  input  logic [HTNUM-1:0]   w_init,
  input  logic               d_valid,
  output logic               d_ready,
  input  logic [DATABIT-1:0] d_in,
  input  logic [DATABIT-1:0] err,
  input  logic [HTNUM-1:0]   h_prev,
  output logic [HTNUM-1:0]   w,
  output logic               w_valid,
  output logic               busy
);

  localparam int          Lanes = HTNUM / DATABIT;
  localparam int unsigned PW    = 2 * DATABIT;
  localparam int unsigned AW1   = ACCW + 1;
  localparam int unsigned CntW  = $clog2(NSAMP + 1);

  typedef enum logic [1:0] {StIdle, StAcc, StDrain, StUpdate} state_e;

  function automatic logic signed [DATABIT-1:0] sat_data(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] lo;
    hi = PW'({1'b0, {(DATABIT-1){1'b1}}});
    lo = ~hi;
    if (x > hi) begin
      sat_data = hi[DATABIT-1:0];
    end else if (x < lo) begin
      sat_data = lo[DATABIT-1:0];
    end else begin
      sat_data = x[DATABIT-1:0];
    end
  endfunction

  function automatic logic signed [ACCW-1:0] sat_acc(input logic signed [AW1-1:0] x);
    logic signed [AW1-1:0] hi;
    logic signed [AW1-1:0] lo;
    hi = AW1'({1'b0, {(ACCW-1){1'b1}}});
    lo = ~hi;
    if (x > hi) begin
      sat_acc = hi[ACCW-1:0];
    end else if (x < lo) begin
      sat_acc = lo[ACCW-1:0];
    end else begin
      sat_acc = x[ACCW-1:0];
    end
  endfunction

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic signed [DATABIT-1:0]  err_q, din_q;
  logic [HTNUM-1:0]           h0_q, h1_q;
  logic signed [DATABIT-1:0]  p_q, p_d;
  logic signed [DATABIT-1:0]  g_q [Lanes];
  logic signed [DATABIT-1:0]  g_d [Lanes];
  logic signed [ACCW-1:0]     acc_q [Lanes];
  logic signed [ACCW-1:0]     acc_d [Lanes];
  logic [HTNUM-1:0]           w_q, w_d;
  logic                       w_valid_q, w_valid_d;
  logic                       accept;
  logic signed [PW-1:0]       prod;
  logic signed [PW-1:0]       lane_prod [Lanes];
  logic signed [ACCW-1:0]     delta [Lanes];
  logic signed [PW-1:0]       diff [Lanes];
  logic signed [DATABIT-1:0]  w_upd [Lanes];

  assign accept  = d_valid && (state_q == StAcc);
  assign d_ready = (state_q == StAcc);
  assign busy    = (state_q == StDrain) || (state_q == StUpdate);
  assign w       = w_q;
  assign w_valid = w_valid_q;

  assign prod = PW'(err_q) * PW'(din_q);

  // Arithmetic datapath: product stage, per-lane gradient and candidate new weights.
  always_comb begin
    p_d = sat_data(prod >>> FRAC);
    for (int j = 0; j < Lanes; j++) begin
      lane_prod[j] = PW'(p_q) * PW'($signed(h1_q[j*DATABIT +: DATABIT]));
      g_d[j]       = sat_data(lane_prod[j] >>> FRAC);
      delta[j]     = acc_q[j] >>> LR_SHIFT;
      diff[j]      = PW'($signed(w_q[j*DATABIT +: DATABIT])) - PW'(delta[j]);
      w_upd[j]     = sat_data(diff[j]);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    v0_d      = accept;
    v1_d      = v0_q;
    v2_d      = v1_q;
    w_d       = w_q;
    w_valid_d = 1'b0;
    for (int j = 0; j < Lanes; j++) begin
      acc_d[j] = v2_q ? sat_acc(AW1'(acc_q[j]) + AW1'(g_q[j])) : acc_q[j];
    end

    unique case (state_q)
      StIdle: ;
      StAcc: begin
        if (accept) begin
          if (cnt_q == CntW'(NSAMP - 1)) begin
            cnt_d   = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // v2 is consumed on the exit edge, so only the first two stages must be empty.
      StDrain: begin
        if (!v0_q && !v1_q) state_d = StUpdate;
      end
      StUpdate: begin
        for (int j = 0; j < Lanes; j++) begin
          w_d[j*DATABIT +: DATABIT] = w_upd[j];
          acc_d[j]                  = '0;
        end
        w_valid_d = 1'b1;
        state_d   = StAcc;
      end
      default: state_d = StIdle;
    endcase

    if (init) begin
      w_d       = w_init;
      cnt_d     = '0;
      v0_d      = 1'b0;
      v1_d      = 1'b0;
      v2_d      = 1'b0;
      w_valid_d = 1'b0;
      state_d   = StAcc;
      for (int j = 0; j < Lanes; j++) acc_d[j] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      err_q     <= '0;
      din_q     <= '0;
      h0_q      <= '0;
      h1_q      <= '0;
      p_q       <= '0;
      w_q       <= '0;
      w_valid_q <= 1'b0;
      for (int j = 0; j < Lanes; j++) begin
        g_q[j]   <= '0;
        acc_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      if (accept) begin
        err_q <= err;
        din_q <= d_in;
        h0_q  <= h_prev;
      end
      p_q       <= p_d;
      h1_q      <= h0_q;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      for (int j = 0; j < Lanes; j++) begin
        g_q[j]   <= g_d[j];
        acc_q[j] <= acc_d[j];
      end
    end
  end

endmodule

// File: tb/tb_grad_weight_update.sv
// Randomised and directed bench for grad_weight_update against a batch-level arithmetic model.
module tb_grad_weight_update;

  logic        clk = 1'b0;
  logic        rst_n, init, d_valid, d_ready, w_valid, busy;
  logic [63:0] w_init, h_prev, w;
  logic [15:0] d_in, err;

  always #5 clk = ~clk;

  grad_weight_update dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (init),
    .w_init (w_init),
    .d_valid(d_valid),
    .d_ready(d_ready),
    .d_in   (d_in),
    .err    (err),
    .h_prev (h_prev),
    .w      (w),
    .w_valid(w_valid),
    .busy   (busy)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  int          mw [4];
  int          mw_next [4];
  bit          m_active = 1'b0;
  int          pend = -1;
  bit          exp_wv;
  int          q_err [$];
  int          q_din [$];
  logic [63:0] q_h [$];
  int          wv_cyc_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic longint sat_acc(input longint x);
    if (x > 524287) return 524287;
    if (x < -524288) return -524288;
    return x;
  endfunction

  function automatic int lane(input logic [63:0] v, input int j);
    logic signed [15:0] s;
    s = v[16*j +: 16];
    return int'(s);
  endfunction

  function automatic logic [63:0] pack_w();
    logic [63:0] r;
    for (int j = 0; j < 4; j++) r[16*j +: 16] = mw[j][15:0];
    return r;
  endfunction

  // Whole-batch reference: evaluate every sample's gradient in order, then step the weights.
  task automatic compute_batch();
    longint acc [4];
    longint p, g;
    for (int j = 0; j < 4; j++) acc[j] = 0;
    for (int s = 0; s < q_err.size(); s++) begin
      p = sat16((longint'(q_err[s]) * longint'(q_din[s])) >>> 14);
      for (int j = 0; j < 4; j++) begin
        g      = sat16((p * longint'(lane(q_h[s], j))) >>> 14);
        acc[j] = sat_acc(acc[j] + g);
      end
    end
    for (int j = 0; j < 4; j++) mw_next[j] = sat16(longint'(mw[j]) - (acc[j] >>> 6));
  endtask

  task automatic clear_batch();
    q_err.delete();
    q_din.delete();
    q_h.delete();
    pend = -1;
  endtask

  task automatic tick();
    bit acc_m;
    acc_m  = !rst_n && !init && d_valid && m_active && (pend < 0);
    exp_wv = 1'b0;
    if (rst_n) begin
      for (int j = 0; j < 4; j++) mw[j] = 0;
      m_active = 1'b0;
      clear_batch();
    end else if (init) begin
      for (int j = 0; j < 4; j++) mw[j] = lane(w_init, j);
      m_active = 1'b1;
      clear_batch();
    end else begin
      if (acc_m) begin
        q_err.push_back(lane({48'h0, err}, 0));
        q_din.push_back(lane({48'h0, d_in}, 0));
        q_h.push_back(h_prev);
        if (q_err.size() == 4) begin
          compute_batch();
          q_err.delete();
          q_din.delete();
          q_h.delete();
          pend = cyc + 5;
        end
      end
      if (pend == cyc + 1) begin
        for (int j = 0; j < 4; j++) mw[j] = mw_next[j];
        pend   = -1;
        exp_wv = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_eq("w", w, pack_w());
    check_eq("w_valid", {63'h0, w_valid}, {63'h0, exp_wv});
    check_eq("d_ready", {63'h0, d_ready}, {63'h0, (m_active && pend < 0)});
    check_eq("busy", {63'h0, busy}, {63'h0, (pend >= 0)});
    if (w_valid === 1'b1) wv_cyc_q.push_back(cyc);
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_init(input logic [63:0] wi);
    init   = 1'b1;
    w_init = wi;
    tick();
    init = 1'b0;
  endtask

  task automatic set_sample(input logic [15:0] e, input logic [15:0] d, input logic [63:0] h);
    err    = e;
    d_in   = d;
    h_prev = h;
  endtask

  function automatic logic [15:0] rnd16();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(1) == 0) v = 16'($signed(v) >>> 3);
    return v;
  endfunction

  initial begin
    int d;
    rst_n   = 1'b1;
    init    = 1'b0;
    d_valid = 1'b0;
    w_init  = '0;
    set_sample(16'h0, 16'h0, 64'h0);

    // Reset, then an unaccepted sample stream in IDLE.
    ticks(2);
    rst_n = 1'b0;
    check_eq("s1_reset_w", w, 64'h0);
    d_valid = 1'b1;
    set_sample(16'h4000, 16'h4000, {4{16'h4000}});
    ticks(5);
    d_valid = 1'b0;
    check_eq("s1_no_wv", 64'(wv_cyc_q.size()), 64'd0);

    // Unit gradient on every lane.
    do_init({4{16'h1000}});
    busy_cnt = 0;
    d_valid  = 1'b1;
    ticks(4);
    d_valid = 1'b0;
    ticks(6);
    check_eq("s2_w", w, {4{16'h0c00}});
    check_eq("s2_busy_cycles", 64'(busy_cnt), 64'd4);

    // Negative gradient on lane 0 only.
    do_init({4{16'h1000}});
    set_sample(16'hc000, 16'h4000, {48'h0, 16'h2000});
    d_valid = 1'b1;
    ticks(4);
    d_valid = 1'b0;
    ticks(6);
    check_eq("s3_w", w, 64'h1000_1000_1000_1200);

    // Saturation at every stage.
    do_init({16'h1000, 16'h1000, 16'h1000, 16'h7f00});
    set_sample(16'h8000, 16'h7fff, {48'h0, 16'h7fff});
    d_valid = 1'b1;
    ticks(4);
    d_valid = 1'b0;
    ticks(6);
    check_eq("s4_w", w, 64'h1000_1000_1000_7fff);

    // Continuous valid across two batches.
    do_init({4{16'h1000}});
    wv_cyc_q.delete();
    set_sample(16'h4000, 16'h4000, {4{16'h4000}});
    d_valid = 1'b1;
    ticks(15);
    d_valid = 1'b0;
    ticks(6);
    check_eq("s5_w", w, {4{16'h0800}});
    check_eq("s5_wv_count", 64'(wv_cyc_q.size()), 64'd2);
    d = (wv_cyc_q.size() >= 2) ? wv_cyc_q[1] - wv_cyc_q[0] : -1;
    check_eq("s5_wv_spacing", 64'(d), 64'd8);

    // Mid-batch abort by init (with a coincident valid), then by reset.
    do_init({4{16'h1000}});
    wv_cyc_q.delete();
    d_valid = 1'b1;
    ticks(2);
    do_init({4{16'h1000}});
    ticks(4);
    d_valid = 1'b0;
    ticks(6);
    check_eq("s6_w", w, {4{16'h0c00}});
    check_eq("s6_wv_count", 64'(wv_cyc_q.size()), 64'd1);
    d_valid = 1'b1;
    ticks(2);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    ticks(3);
    d_valid = 1'b0;
    check_eq("s6_reset_w", w, 64'h0);
    check_eq("s6_reset_ready", {63'h0, d_ready}, 64'h0);

    // Random traffic with occasional re-init.
    do_init({$urandom, $urandom});
    for (int i = 0; i < 400; i++) begin
      d_valid = ($urandom_range(3) != 0);
      set_sample(rnd16(), rnd16(), {rnd16(), rnd16(), rnd16(), rnd16()});
      if ($urandom_range(99) == 0) begin
        init   = 1'b1;
        w_init = {rnd16(), rnd16(), rnd16(), rnd16()};
      end
      tick();
      init = 1'b0;
    end
    d_valid = 1'b0;
    ticks(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
